// File: rtl/symbol_lut_ctrl.sv
// Sequencer for the symbol-to-code lookup buffer: loads the LUT from a config
// stream, then streams symbols through it into a 2-entry output FIFO.
module symbol_lut_ctrl #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int SYMBOL_COUNT = 16,
    parameter int OUTPUT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [SYMBOL_WIDTH:0]   load_len,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SYMBOL_WIDTH-1:0] cfg_symbol,
    input  logic [OUTPUT_WIDTH-1:0] cfg_code,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_code,
    output logic                    out_miss,
    output logic                    busy,
    output logic                    buf_config_en,
    output logic [SYMBOL_WIDTH-1:0] buf_config_symbol,
    output logic [OUTPUT_WIDTH-1:0] buf_config_output,
    output logic [SYMBOL_WIDTH-1:0] buf_symbol,
    input  logic [OUTPUT_WIDTH-1:0] buf_out
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [SYMBOL_WIDTH:0] LEN_MAX = (SYMBOL_WIDTH+1)'(SYMBOL_COUNT);
    localparam logic [SYMBOL_WIDTH:0] LEN_ONE = (SYMBOL_WIDTH+1)'(1);

    state_t                    state_q;
    logic [SYMBOL_WIDTH:0]     remain_q;
    logic [SYMBOL_COUNT-1:0]   loaded_q;
    logic                      inflight_q;
    logic                      inflight_miss_q;
    logic [OUTPUT_WIDTH-1:0]   fifo_code_q [2];
    logic                      fifo_miss_q [2];
    logic                      rd_ptr_q;
    logic                      wr_ptr_q;
    logic [1:0]                cnt_q;

    logic                      cfg_acc;
    logic                      in_acc;
    logic                      pop;
    logic [2:0]                occ;
    logic                      load_req;
    logic [SYMBOL_WIDTH:0]     len_clamped;

    always_comb begin
        load_req    = load_start && (load_len != '0);
        len_clamped = (load_len > LEN_MAX) ? LEN_MAX : load_len;
        cfg_acc     = (state_q == LOAD) && cfg_valid;
        pop         = (cnt_q != 2'd0) && out_ready;
        occ         = {1'b0, cnt_q} + {2'b00, inflight_q};
        // A pop in the same cycle frees a slot, which keeps 1 symbol/cycle
        // flowing while out_ready stays high.
        in_ready    = (state_q == RUN) && ((occ < 3'd2) || ((occ == 3'd2) && pop));
        in_acc      = in_valid && in_ready;
    end

    assign cfg_ready         = (state_q == LOAD);
    assign busy              = (state_q != IDLE);
    assign buf_config_en     = cfg_acc;
    assign buf_config_symbol = cfg_acc ? cfg_symbol : '0;
    assign buf_config_output = cfg_acc ? cfg_code : '0;
    assign buf_symbol        = in_acc ? in_symbol : '0;
    assign out_valid         = (cnt_q != 2'd0);
    assign out_code          = out_valid ? fifo_code_q[rd_ptr_q] : '0;
    assign out_miss          = out_valid && fifo_miss_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            remain_q        <= '0;
            loaded_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_miss_q <= 1'b0;
            fifo_code_q[0]  <= '0;
            fifo_code_q[1]  <= '0;
            fifo_miss_q[0]  <= 1'b0;
            fifo_miss_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            cnt_q           <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_req) begin
                        remain_q <= len_clamped;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_acc) begin
                        loaded_q[cfg_symbol] <= 1'b1;
                        remain_q             <= remain_q - LEN_ONE;
                        if (remain_q == LEN_ONE) state_q <= RUN;
                    end
                end
                RUN: begin
                    if (load_req) begin
                        remain_q <= len_clamped;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight_q && (cnt_q == 2'd0)) state_q <= LOAD;
                end
                default: state_q <= IDLE;
            endcase

            // Miss flag is captured with the accept so it lines up with buf_out.
            inflight_q <= in_acc;
            if (in_acc) inflight_miss_q <= !loaded_q[in_symbol];

            if (inflight_q) begin
                fifo_code_q[wr_ptr_q] <= buf_out;
                fifo_miss_q[wr_ptr_q] <= inflight_miss_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;

            case ({inflight_q, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_lut_ctrl.sv
// Bench for symbol_lut_ctrl: models the external lookup buffer and checks every
// delivered code against a scoreboard filled at symbol-accept time.
module tb_symbol_lut_ctrl;

    localparam int SW = 4;
    localparam int SC = 16;
    localparam int OW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [SW:0]   load_len;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [SW-1:0] cfg_symbol;
    logic [OW-1:0] cfg_code;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_symbol;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_code;
    logic          out_miss;
    logic          busy;
    logic          buf_config_en;
    logic [SW-1:0] buf_config_symbol;
    logic [OW-1:0] buf_config_output;
    logic [SW-1:0] buf_symbol;
    logic [OW-1:0] buf_out;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;

    typedef struct packed {
        logic [OW-1:0] code;
        logic          miss;
    } exp_t;

    exp_t          sb [$];
    logic [OW-1:0] ref_lut    [SC];
    logic          ref_loaded [SC];
    logic [OW-1:0] buf_lut    [SC];

    always #5 clk = ~clk;

    symbol_lut_ctrl #(.SYMBOL_WIDTH(SW), .SYMBOL_COUNT(SC), .OUTPUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_symbol(cfg_symbol), .cfg_code(cfg_code),
        .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_miss(out_miss),
        .busy(busy), .buf_config_en(buf_config_en), .buf_config_symbol(buf_config_symbol),
        .buf_config_output(buf_config_output), .buf_symbol(buf_symbol), .buf_out(buf_out)
    );

    // External lookup buffer: write port plus one-cycle registered read, same reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SC; i++) buf_lut[i] <= '0;
            buf_out <= '0;
        end else begin
            if (buf_config_en) buf_lut[buf_config_symbol] <= buf_config_output;
            buf_out <= buf_lut[buf_symbol];
        end
    end

    // Scoreboard: expectations pushed on accept, compared on each delivered code.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cfg_valid && cfg_ready) begin
                ref_lut[cfg_symbol]    = cfg_code;
                ref_loaded[cfg_symbol] = 1'b1;
            end
            if (out_valid && out_ready) begin
                total++;
                out_cnt++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got code=%h miss=%b, required no output", out_code, out_miss);
                end else begin
                    e = sb.pop_front();
                    if ({out_code, out_miss} !== {e.code, e.miss}) begin
                        bad++;
                        $display("FAIL sb_code: got code=%h miss=%b, required code=%h miss=%b",
                                 out_code, out_miss, e.code, e.miss);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back({ref_lut[in_symbol], !ref_loaded[in_symbol]});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref;
        sb.delete();
        for (int i = 0; i < SC; i++) begin
            ref_lut[i]    = '0;
            ref_loaded[i] = 1'b0;
        end
    endtask

    task automatic start_load(input int len);
        load_start = 1'b1;
        load_len   = (SW+1)'(len);
        tick();
        load_start = 1'b0;
        load_len   = '0;
    endtask

    task automatic cfg_write(input logic [SW-1:0] sym, input logic [OW-1:0] code);
        bit ok = 0;
        cfg_valid  = 1'b1;
        cfg_symbol = sym;
        cfg_code   = code;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1;
                total++;
                if ({buf_config_en, buf_config_symbol, buf_config_output} !== {1'b1, sym, code}) begin
                    bad++;
                    $display("FAIL cfg_passthru: got en=%b sym=%h code=%h, required en=1 sym=%h code=%h",
                             buf_config_en, buf_config_symbol, buf_config_output, sym, code);
                end
            end
            tick();
            if (ok) break;
        end
        cfg_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL cfg_timeout: got cfg_ready=0 for 40 cycles, required 1");
        end
    endtask

    task automatic send_symbol(input logic [SW-1:0] sym);
        bit ok = 0;
        in_valid  = 1'b1;
        in_symbol = sym;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                total++;
                if (buf_symbol !== sym) begin
                    bad++;
                    $display("FAIL buf_symbol: got %h, required %h", buf_symbol, sym);
                end
            end
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_timeout: got in_ready=0 for 40 cycles, required 1");
        end
    endtask

    task automatic wait_drain;
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain: got %0d codes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_start = 1'b0; load_len = '0;
        cfg_valid = 1'b0; cfg_symbol = '0; cfg_code = '0;
        in_valid = 1'b0; in_symbol = '0; out_ready = 1'b0;
        clear_ref();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cfg_ready, in_ready, out_valid, out_miss, busy, buf_config_en, buf_config_symbol,
             buf_config_output, buf_symbol, out_code} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got cfg_ready=%b in_ready=%b out_valid=%b busy=%b cfg_en=%b, required all 0",
                     cfg_ready, in_ready, out_valid, busy, buf_config_en);
        end
        tick();
        rst = 1'b0;
        tick();
        start_load(0);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL len_zero_idle: got busy=%b, required 0", busy);
        end
        tick();
    endtask

    task automatic test_basic;
        logic [SW-1:0] syms [4];
        syms[0] = 4'd3; syms[1] = 4'd7; syms[2] = 4'd0; syms[3] = 4'd15;
        start_load(4);
        @(negedge clk);
        total++;
        if ({busy, cfg_ready, in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL load_state: got busy=%b cfg_ready=%b in_ready=%b, required 1 1 0", busy, cfg_ready, in_ready);
        end
        tick();
        cfg_write(4'd3, 10'h155);
        cfg_write(4'd7, 10'h2AA);
        cfg_write(4'd0, 10'h001);
        cfg_write(4'd15, 10'h3FF);
        @(negedge clk);
        total++;
        if ({cfg_ready, in_ready, buf_config_en} !== 3'b010) begin
            bad++;
            $display("FAIL run_entry: got cfg_ready=%b in_ready=%b cfg_en=%b, required 0 1 0", cfg_ready, in_ready, buf_config_en);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid  = (i < 4);
            in_symbol = (i < 4) ? syms[i] : '0;
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready: cycle %0d got in_ready=%b, required 1", i, in_ready);
            end
            total++;
            if (out_valid !== (i >= 2 && i <= 5)) begin
                bad++;
                $display("FAIL stream_latency: cycle %0d got out_valid=%b, required %b", i, out_valid, (i >= 2 && i <= 5));
            end
            tick();
        end
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_miss;
        bit seen = 0;
        send_symbol(4'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                total++;
                if ({out_code, out_miss} !== {10'h000, 1'b1}) begin
                    bad++;
                    $display("FAIL miss_code: got code=%h miss=%b, required code=000 miss=1", out_code, out_miss);
                end
            end
            tick();
            if (seen) break;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL miss_timeout: got out_valid=0, required 1");
        end
        wait_drain();
    endtask

    task automatic test_backpressure;
        logic [SW-1:0] syms [10];
        int idx = 0;
        int base;
        bit acc;
        syms[0] = 4'd3; syms[1] = 4'd7; syms[2] = 4'd0; syms[3] = 4'd15; syms[4] = 4'd5;
        syms[5] = 4'd3; syms[6] = 4'd7; syms[7] = 4'd0; syms[8] = 4'd15; syms[9] = 4'd9;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_symbol = syms[idx];
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        total++;
        if (idx != 2) begin
            bad++;
            $display("FAIL bp_accepts: got %0d accepted under backpressure, required 2", idx);
        end
        total++;
        if ({out_valid, in_ready, out_code} !== {1'b1, 1'b0, 10'h155}) begin
            bad++;
            $display("FAIL bp_hold: got out_valid=%b in_ready=%b code=%h, required 1 0 155", out_valid, in_ready, out_code);
        end
        total++;
        if (sb.size() != 2) begin
            bad++;
            $display("FAIL bp_pending: got %0d pending, required 2", sb.size());
        end
        base = out_cnt;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && idx < 10; c++) begin
            in_symbol = syms[idx];
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        total++;
        if (idx != 10) begin
            bad++;
            $display("FAIL bp_stream: got %0d accepted, required 10", idx);
        end
        wait_drain();
        total++;
        if (out_cnt - base != 10) begin
            bad++;
            $display("FAIL bp_delivered: got %0d codes, required 10", out_cnt - base);
        end
    endtask

    task automatic test_duplicates;
        bit seen = 0;
        start_load(2);
        cfg_write(4'd2, 10'h010);
        cfg_write(4'd2, 10'h020);
        @(negedge clk);
        total++;
        if ({cfg_ready, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL dup_run: got cfg_ready=%b in_ready=%b, required 0 1", cfg_ready, in_ready);
        end
        tick();
        send_symbol(4'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                total++;
                if ({out_code, out_miss} !== {10'h020, 1'b0}) begin
                    bad++;
                    $display("FAIL dup_code: got code=%h miss=%b, required code=020 miss=0", out_code, out_miss);
                end
            end
            tick();
            if (seen) break;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL dup_timeout: got out_valid=0, required 1");
        end
        wait_drain();
    endtask

    task automatic test_reload_drain;
        int n = 0;
        int base;
        bit got = 0;
        bit acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            in_symbol = (n == 0) ? 4'd3 : 4'd7;
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) n++;
        end
        in_valid = 1'b0;
        tick();
        start_load(1);
        @(negedge clk);
        total++;
        if ({busy, cfg_ready, in_ready, out_valid} !== 4'b1001) begin
            bad++;
            $display("FAIL drain_state: got busy=%b cfg_ready=%b in_ready=%b out_valid=%b, required 1 0 0 1",
                     busy, cfg_ready, in_ready, out_valid);
        end
        tick();
        tick();
        @(negedge clk);
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL drain_hold: got cfg_ready=%b with codes pending, required 0", cfg_ready);
        end
        tick();
        base = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                got = 1;
                total++;
                if (out_cnt - base != 2) begin
                    bad++;
                    $display("FAIL drain_order: got %0d codes before LOAD, required 2", out_cnt - base);
                end
            end
            tick();
            if (got) break;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got cfg_ready=0, required 1");
        end
        cfg_write(4'd7, 10'h0AB);
        send_symbol(4'd7);
        send_symbol(4'd3);
        wait_drain();
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        start_load(4);
        cfg_write(4'd9, 10'h111);
        cfg_write(4'd10, 10'h222);
        rst = 1'b1;
        clear_ref();
        @(negedge clk);
        total++;
        if ({busy, cfg_ready, out_valid, in_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b cfg_ready=%b out_valid=%b in_ready=%b, required all 0",
                     busy, cfg_ready, out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        start_load(1);
        cfg_write(4'd9, 10'h123);
        send_symbol(4'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                total++;
                if ({out_code, out_miss} !== {10'h000, 1'b1}) begin
                    bad++;
                    $display("FAIL rst_miss: got code=%h miss=%b, required code=000 miss=1", out_code, out_miss);
                end
            end
            tick();
            if (seen) break;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL rst_timeout: got out_valid=0, required 1");
        end
        send_symbol(4'd10);
        send_symbol(4'd9);
        wait_drain();
    endtask

    task automatic test_len_rules;
        start_load(0);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL len_zero_run: got in_ready=%b, required 1", in_ready);
        end
        tick();
        start_load(20);
        for (int i = 0; i < 15; i++) cfg_write(SW'(i), OW'(i * 37 + 1));
        @(negedge clk);
        total++;
        if ({cfg_ready, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL clamp_15: got cfg_ready=%b in_ready=%b, required 1 0", cfg_ready, in_ready);
        end
        tick();
        cfg_write(4'd15, OW'(15 * 37 + 1));
        @(negedge clk);
        total++;
        if ({cfg_ready, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL clamp_16: got cfg_ready=%b in_ready=%b, required 0 1", cfg_ready, in_ready);
        end
        tick();
        send_symbol(4'd15);
        send_symbol(4'd4);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_miss();
        test_backpressure();
        test_duplicates();
        test_reload_drain();
        test_reset_mid();
        test_len_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
